gray_frame_ctrl: RTL and testbench
==================================

GRAY_FRAME_CTRL -- requirements
Module: gray_frame_ctrl

Interface
REQ-001 Parameter H_ACTIVE, default 1280, active pixels per line accepted (2..2047).
REQ-002 Parameter V_ACTIVE, default 960, active lines per frame accepted (2..2047).
REQ-003 iCLK  input  1  sole clock; all logic on rising edge.
REQ-004 iRST  input  1  reset, synchronous, active-high.
REQ-005 iFVAL  input  1  sensor frame valid.
REQ-006 iLVAL  input  1  sensor line valid; a pixel is present when iFVAL&iLVAL.
REQ-007 iDATA  input  12  raw Bayer pixel.
REQ-008 iSTART  input  1  single-cycle capture request.
REQ-009 iSTOP  input  1  single-cycle stop request.
REQ-010 oDATA  output  12  accepted pixel, to the Bayer-to-gray datapath.
REQ-011 oDVAL  output  1  oDATA/oX_Cont/oY_Cont valid this cycle.
REQ-012 oX_Cont  output  11  column of pixel on oDATA.
REQ-013 oY_Cont  output  11  row of pixel on oDATA.
REQ-014 oBUSY  output  1  high in any state except IDLE.
REQ-015 oFRAME_DONE  output  1  one-cycle pulse at frame end.
REQ-016 oFRAME_ERR  output  1  sticky: last frame ended short.
REQ-017 oFrame_Cont  output  16  completed-frame counter, wraps 0xFFFF->0.

Function
REQ-018 States SHALL be IDLE, ARM, CAPTURE, FRAME_END.
REQ-019 IDLE: iSTART&!iSTOP -> ARM, clear oFRAME_ERR; iSTART&iSTOP -> stay IDLE; iSTART outside IDLE ignored.
REQ-020 ARM: iFVAL rising edge (registered previous iFVAL 0, current 1) -> CAPTURE, X=Y=0; iSTOP -> IDLE; a frame already in progress on entry SHALL NOT be captured.
REQ-021 CAPTURE: pixel accepted when iFVAL&iLVAL and X count < H_ACTIVE; oDATA=iDATA, oDVAL=1, oX_Cont/oY_Cont=current X/Y, all registered, latency exactly 1 cycle.
REQ-022 X SHALL increment per accepted pixel; pixels after X reaches H_ACTIVE in a line dropped (oDVAL=0).
REQ-023 iLVAL falling edge with >=1 pixel accepted in line: X<=0, Y<=Y+1; if that line was row V_ACTIVE-1 -> FRAME_END, oFRAME_ERR unchanged.
REQ-024 Short line (fewer than H_ACTIVE pixels) SHALL still advance Y per REQ-023, no error.
REQ-025 iFVAL falling in CAPTURE before row V_ACTIVE-1 completes -> FRAME_END, oFRAME_ERR<=1.
REQ-026 iSTOP in CAPTURE SHALL set stop_pending; frame completes normally; stop_pending cleared on leaving FRAME_END.
REQ-027 FRAME_END lasts one cycle: oFRAME_DONE=1, oFrame_Cont+1, oDVAL=0; next state per REQ-031/032.
REQ-028 oDVAL SHALL be 0 in IDLE, ARM, FRAME_END and for one cycle after any state exit from CAPTURE.
REQ-029 iFVAL falling and end of row V_ACTIVE-1 in same cycle: normal completion, no error.

Reset
REQ-030 iRST SHALL force IDLE, stop_pending=0, X=Y=0, and all outputs 0 (oDATA, oDVAL, oX_Cont, oY_Cont, oBUSY, oFRAME_DONE, oFRAME_ERR, oFrame_Cont) on the next edge; reset mid-frame aborts capture with no oFRAME_DONE pulse and no count increment.

Configuration
REQ-031 GRAY_FRAME_CTRL_CONTINUOUS_EN defined: FRAME_END -> ARM unless stop_pending, then IDLE; continuous capture of successive frames.
REQ-032 Macro undefined: FRAME_END -> IDLE always (single-shot; one iSTART yields at most one frame).

Verification (H_ACTIVE=4, V_ACTIVE=2)
REQ-033 iSTART in IDLE, full 2x4 frame -> 8 oDVAL pulses, coords (0,0)..(3,1) in order, iDATA echoed 1 cycle late, one oFRAME_DONE, oFrame_Cont=1, oFRAME_ERR=0.
REQ-034 iSTART while iFVAL already high -> no oDVAL until next iFVAL rise; that frame captured fully.
REQ-035 Line of 6 pixels -> only X=0..3 forwarded, pixels 5-6 dropped; line of 2 pixels -> X=0,1 forwarded, Y advances.
REQ-036 iFVAL falls after row 0 -> oFRAME_DONE pulse, oFRAME_ERR=1, held until next accepted iSTART.
REQ-037 Continuous build, iSTOP mid-frame 1 -> frame 1 completes, oFrame_Cont=1, returns IDLE, oBUSY=0; single-shot build, two frames present -> only first captured.
REQ-038 iRST asserted at pixel (2,1) -> next cycle all outputs 0, IDLE, no oFRAME_DONE.

Source files
------------

// File: rtl/gray_frame_ctrl_if.sv
// Sensor-side and capture-side signal bundle for gray_frame_ctrl.
// The master drives the sensor inputs and receives the accepted pixel stream.
interface gray_frame_ctrl_if;
    logic        iFVAL;
    logic        iLVAL;
    logic [11:0] iDATA;
    logic        iSTART;
    logic        iSTOP;
    logic [11:0] oDATA;
    logic        oDVAL;
    logic [10:0] oX_Cont;
    logic [10:0] oY_Cont;
    logic        oBUSY;
    logic        oFRAME_DONE;
    logic        oFRAME_ERR;
    logic [15:0] oFrame_Cont;

    modport master (
        output iFVAL, iLVAL, iDATA, iSTART, iSTOP,
        input  oDATA, oDVAL, oX_Cont, oY_Cont, oBUSY, oFRAME_DONE, oFRAME_ERR, oFrame_Cont
    );

    modport slave (
        input  iFVAL, iLVAL, iDATA, iSTART, iSTOP,
        output oDATA, oDVAL, oX_Cont, oY_Cont, oBUSY, oFRAME_DONE, oFRAME_ERR, oFrame_Cont
    );
endinterface

// File: rtl/gray_frame_ctrl.sv
// Frame capture controller: arms on iSTART, captures one H_ACTIVE x V_ACTIVE frame from the sensor.
// Define GRAY_FRAME_CTRL_CONTINUOUS_EN to re-arm after each frame until iSTOP is seen.
module gray_frame_ctrl #(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 960
) (
    input logic              iCLK,
    input logic              iRST,
    gray_frame_ctrl_if.slave bus
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ARM       = 2'd1;
    localparam logic [1:0] CAPTURE   = 2'd2;
    localparam logic [1:0] FRAME_END = 2'd3;

    localparam logic [10:0] LINE_LEN = 11'(H_ACTIVE);
    localparam logic [10:0] LAST_ROW = 11'(V_ACTIVE - 1);

    logic [1:0]  state;
    logic [10:0] xCnt;
    logic [10:0] yCnt;
    logic        prevFval;
    logic        prevLval;
    logic        stopPending;

    logic pixelIn;
    logic lineEnd;
    logic lastRowEnd;
    logic fvalRise;
    logic fvalFall;

    // A line only counts as finished if it delivered at least one pixel.
    assign pixelIn    = bus.iFVAL & bus.iLVAL & (xCnt < LINE_LEN);
    assign lineEnd    = prevLval & ~bus.iLVAL & (xCnt != 11'd0);
    assign lastRowEnd = lineEnd & (yCnt == LAST_ROW);
    assign fvalRise   = bus.iFVAL & ~prevFval;
    assign fvalFall   = prevFval & ~bus.iFVAL;

    assign bus.oBUSY = (state != IDLE);

    always_ff @(posedge iCLK) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (iRST) begin
            state           <= IDLE;
            xCnt            <= '0;
            yCnt            <= '0;
            prevFval        <= 1'b0;
            prevLval        <= 1'b0;
            stopPending     <= 1'b0;
            bus.oDATA       <= '0;
            bus.oDVAL       <= 1'b0;
            bus.oX_Cont     <= '0;
            bus.oY_Cont     <= '0;
            bus.oFRAME_DONE <= 1'b0;
            bus.oFRAME_ERR  <= 1'b0;
            bus.oFrame_Cont <= '0;
        end else begin
            prevFval        <= bus.iFVAL;
            prevLval        <= bus.iLVAL;
            bus.oDVAL       <= 1'b0;
            bus.oFRAME_DONE <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.iSTART && !bus.iSTOP) begin
                        state          <= ARM;
                        bus.oFRAME_ERR <= 1'b0;
                    end
                end

                // Waiting for a fresh frame start; a frame already running is skipped.
                ARM: begin
                    if (bus.iSTOP) begin
                        state <= IDLE;
                    end else if (fvalRise) begin
                        state <= CAPTURE;
                        xCnt  <= '0;
                        yCnt  <= '0;
                    end
                end

                CAPTURE: begin
                    if (bus.iSTOP) stopPending <= 1'b1;

                    if (pixelIn) begin
                        bus.oDATA   <= bus.iDATA;
                        bus.oDVAL   <= 1'b1;
                        bus.oX_Cont <= xCnt;
                        bus.oY_Cont <= yCnt;
                        xCnt        <= xCnt + 11'd1;
                    end

                    if (lineEnd) begin
                        xCnt <= '0;
                        yCnt <= yCnt + 11'd1;
                    end

                    // Completing the last row wins over a coincident iFVAL drop.
                    if (lastRowEnd || fvalFall) begin
                        state           <= FRAME_END;
                        bus.oFRAME_DONE <= 1'b1;
                        bus.oFrame_Cont <= bus.oFrame_Cont + 16'd1;
                        if (!lastRowEnd) bus.oFRAME_ERR <= 1'b1;
                    end
                end

                FRAME_END: begin
                    stopPending <= 1'b0;
`ifdef GRAY_FRAME_CTRL_CONTINUOUS_EN
                    state <= stopPending ? IDLE : ARM;
`else
                    state <= IDLE;
`endif
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gray_frame_ctrl.sv
// Self-checking bench for gray_frame_ctrl (H_ACTIVE=4, V_ACTIVE=2): frame-level model plus per-cycle compare.
// Honours GRAY_FRAME_CTRL_CONTINUOUS_EN the same way as the design.
`timescale 1ns/1ps
module tb_gray_frame_ctrl;

    localparam int H = 4;
    localparam int V = 2;
    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_CAP   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    gray_frame_ctrl_if bus ();

    gray_frame_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .iCLK (clk),
        .iRST (rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nCmp = 0;
    int nBad = 0;

    task automatic check(input string name, input int act, input int exp);
        nCmp++;
        if (act != exp) begin
            nBad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame-level model: capture mode, pending stop, and scheduled output events per cycle.
    int          mMode = M_IDLE;
    int          mArmTick = 0;
    int          mCnt = 0;
    bit          mStopPending = 1'b0;
    logic [33:0] expPix [int];
    bit          expDone[int];
    int          evBusy [int];
    int          evErr  [int];
    int          evCnt  [int];

    bit cmpEn = 1'b0;
    int curBusy = 0, curErr = 0, curCnt = 0;
    int pixSeen = 0, doneSeen = 0, lastX = 0, lastY = 0;
    int ct;

    always @(negedge clk) begin
        ct = cyc;
        if (cmpEn) begin
            if (evBusy.exists(ct)) curBusy = evBusy[ct];
            if (evErr.exists(ct))  curErr  = evErr[ct];
            if (evCnt.exists(ct))  curCnt  = evCnt[ct];
            check("busy",  int'(bus.oBUSY),       curBusy);
            check("err",   int'(bus.oFRAME_ERR),  curErr);
            check("count", int'(bus.oFrame_Cont), curCnt);
            check("done",  int'(bus.oFRAME_DONE), int'(expDone.exists(ct)));
            check("dval",  int'(bus.oDVAL),       int'(expPix.exists(ct)));
            if (expPix.exists(ct) && bus.oDVAL) begin
                check("data", int'(bus.oDATA),   int'(expPix[ct][33:22]));
                check("x",    int'(bus.oX_Cont), int'(expPix[ct][21:11]));
                check("y",    int'(bus.oY_Cont), int'(expPix[ct][10:0]));
            end
        end
        if (bus.oDVAL) begin
            pixSeen++;
            lastX = int'(bus.oX_Cont);
            lastY = int'(bus.oY_Cont);
        end
        if (bus.oFRAME_DONE) doneSeen++;
    end

    // NOTE: inputs change #1 after the edge with blocking assignments, so the DUT never races them.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.iSTART = 1'b0;
        bus.iSTOP  = 1'b0;
        bus.iDATA  = 12'($urandom);
    endtask

    function automatic void model_req(input int t, input bit s, input bit p);
        if (p) begin
            if (mMode == M_CAP) mStopPending = 1'b1;
            else if (mMode == M_ARMED) begin
                mMode = M_IDLE;
                evBusy[t+1] = 0;
            end
        end else if (s && mMode == M_IDLE) begin
            mMode = M_ARMED;
            mArmTick = t + 1;
            evBusy[t+1] = 1;
            evErr[t+1] = 0;
        end
    endfunction

    function automatic void frame_done(input int d, input bit isErr);
        expDone[d] = 1'b1;
        mCnt = (mCnt + 1) & 16'hFFFF;
        evCnt[d] = mCnt;
        if (isErr) evErr[d] = 1;
`ifdef GRAY_FRAME_CTRL_CONTINUOUS_EN
        if (mStopPending) begin
            mMode = M_IDLE;
            evBusy[d+1] = 0;
        end else begin
            mMode = M_ARMED;
            mArmTick = d + 1;
        end
`else
        mMode = M_IDLE;
        evBusy[d+1] = 0;
`endif
        mStopPending = 1'b0;
    endfunction

    task automatic pulse(input bit s, input bit p);
        int t;
        tick();
        t = cyc;
        bus.iSTART = s;
        bus.iSTOP  = p;
        model_req(t, s, p);
    endtask

    // One sensor frame; startAt/stopAt (1-based) request a pulse in the gap after that line.
    task automatic drive_frame(input int nl, input int lens[4], input int startAt,
                               input int stopAt, input bit fvalWithLast);
        int t, x, y;
        bit cap;
        tick();
        bus.iFVAL = 1'b1;
        bus.iLVAL = 1'b0;
        t = cyc;
        cap = (mMode == M_ARMED) && (mArmTick <= t);
        if (cap) mMode = M_CAP;
        x = 0;
        y = 0;
        tick();
        for (int i = 0; i < nl; i++) begin
            for (int p = 0; p < lens[i]; p++) begin
                tick();
                bus.iLVAL = 1'b1;
                t = cyc;
                if (cap && x < H) begin
                    expPix[t+1] = {bus.iDATA, 11'(x), 11'(y)};
                    x++;
                end
            end
            tick();
            bus.iLVAL = 1'b0;
            t = cyc;
            if (i == nl - 1 && fvalWithLast) bus.iFVAL = 1'b0;
            if (cap && x > 0) begin
                x = 0;
                y++;
                if (y == V) begin
                    cap = 1'b0;
                    frame_done(t + 1, 1'b0);
                end
            end
            if (i == nl - 1) begin
                if (fvalWithLast && cap) begin
                    cap = 1'b0;
                    frame_done(t + 1, 1'b1);
                end
            end else begin
                tick();
                tick();
                t = cyc;
                bus.iSTART = (startAt == i + 1);
                bus.iSTOP  = (stopAt == i + 1);
                model_req(t, startAt == i + 1, stopAt == i + 1);
            end
        end
        if (!fvalWithLast) begin
            tick();
            bus.iFVAL = 1'b0;
            t = cyc;
            if (cap) frame_done(t + 1, 1'b1);
        end
        repeat (3) tick();
    endtask

    int lens[4];
    int pixBase;
    int doneBase;

    initial begin
        bus.iFVAL = 1'b0;
        bus.iLVAL = 1'b0;
        bus.iDATA = '0;
        bus.iSTART = 1'b0;
        bus.iSTOP = 1'b0;
        repeat (3) tick();
        check("rst_dval",  int'(bus.oDVAL),       0);
        check("rst_busy",  int'(bus.oBUSY),       0);
        check("rst_err",   int'(bus.oFRAME_ERR),  0);
        check("rst_count", int'(bus.oFrame_Cont), 0);
        rst = 1'b0;
        cmpEn = 1'b1;
        tick();

        // Full 2x4 frame.
        pulse(1'b1, 1'b0);
        drive_frame(2, '{4, 4, 0, 0}, 0, 1, 1'b0);
        check("full_pixels", pixSeen, 8);
        check("full_last_x", lastX, 3);
        check("full_last_y", lastY, 1);
        check("full_done",   doneSeen, 1);
        check("full_count",  int'(bus.oFrame_Cont), 1);
        check("full_err",    int'(bus.oFRAME_ERR), 0);
        check("full_busy",   int'(bus.oBUSY), 0);

        // Start while a frame is running: that frame skipped, the next one captured.
        pixBase = pixSeen;
        drive_frame(2, '{4, 4, 0, 0}, 1, 0, 1'b0);
        check("midstart_pixels", pixSeen - pixBase, 0);
        check("midstart_armed",  int'(bus.oBUSY), 1);
        drive_frame(2, '{4, 4, 0, 0}, 0, 1, 1'b0);
        check("midstart_next_pixels", pixSeen - pixBase, 8);
        check("midstart_count", int'(bus.oFrame_Cont), 2);

        // Long and short lines.
        pixBase = pixSeen;
        pulse(1'b1, 1'b0);
        drive_frame(2, '{6, 2, 0, 0}, 0, 1, 1'b0);
        check("len_pixels", pixSeen - pixBase, 6);
        check("len_last_x", lastX, 1);
        check("len_count",  int'(bus.oFrame_Cont), 3);
        check("len_err",    int'(bus.oFRAME_ERR), 0);

        // Frame ends after row 0: error flag stays until an accepted start.
        pulse(1'b1, 1'b0);
        drive_frame(1, '{4, 0, 0, 0}, 0, 0, 1'b0);
        check("short_count", int'(bus.oFrame_Cont), 4);
        check("short_err",   int'(bus.oFRAME_ERR), 1);
        pulse(1'b1, 1'b1);
        tick();
        check("short_err_held", int'(bus.oFRAME_ERR), 1);
        pulse(1'b1, 1'b0);
        tick();
        check("short_err_clear", int'(bus.oFRAME_ERR), 0);
        // iFVAL drops together with the end of the last row.
        drive_frame(2, '{4, 4, 0, 0}, 0, 1, 1'b1);
        check("same_cycle_count", int'(bus.oFrame_Cont), 5);
        check("same_cycle_err",   int'(bus.oFRAME_ERR), 0);

        // Stop mid-frame, then a second frame that must not be captured.
        pixBase = pixSeen;
        pulse(1'b1, 1'b0);
        drive_frame(2, '{4, 4, 0, 0}, 0, 1, 1'b0);
        drive_frame(2, '{4, 4, 0, 0}, 0, 0, 1'b0);
        check("stop_pixels", pixSeen - pixBase, 8);
        check("stop_count",  int'(bus.oFrame_Cont), 6);
        check("stop_busy",   int'(bus.oBUSY), 0);

        // Randomized frames and requests.
        for (int n = 0; n < 30; n++) begin
            int r, nl;
            r = int'($urandom_range(0, 5));
            if (r <= 2)      pulse(1'b1, 1'b0);
            else if (r == 3) pulse(1'b1, 1'b1);
            else if (r == 4) pulse(1'b0, 1'b1);
            tick();
            nl = int'($urandom_range(1, 3));
            for (int k = 0; k < 4; k++) lens[k] = int'($urandom_range(1, 6));
            drive_frame(nl, lens, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)));
        end

        // Reset in the middle of pixel (2,1).
        cmpEn = 1'b0;
        pulse(1'b1, 1'b0);
        tick();
        bus.iFVAL = 1'b1;
        tick();
        for (int p = 0; p < 4; p++) begin
            tick();
            bus.iLVAL = 1'b1;
        end
        tick();
        bus.iLVAL = 1'b0;
        tick();
        tick();
        for (int p = 0; p < 3; p++) begin
            tick();
            bus.iLVAL = 1'b1;
        end
        rst = 1'b1;
        check("prerst_dval", int'(bus.oDVAL),   1);
        check("prerst_x",    int'(bus.oX_Cont), 1);
        check("prerst_y",    int'(bus.oY_Cont), 1);
        doneBase = doneSeen;
        tick();
        check("rst_mid_data",  int'(bus.oDATA),       0);
        check("rst_mid_dval",  int'(bus.oDVAL),       0);
        check("rst_mid_x",     int'(bus.oX_Cont),     0);
        check("rst_mid_y",     int'(bus.oY_Cont),     0);
        check("rst_mid_busy",  int'(bus.oBUSY),       0);
        check("rst_mid_done",  int'(bus.oFRAME_DONE), 0);
        check("rst_mid_err",   int'(bus.oFRAME_ERR),  0);
        check("rst_mid_count", int'(bus.oFrame_Cont), 0);
        rst = 1'b0;
        tick();
        bus.iLVAL = 1'b0;
        tick();
        bus.iFVAL = 1'b0;
        repeat (4) tick();
        check("rst_no_done", doneSeen - doneBase, 0);
        check("rst_idle",    int'(bus.oBUSY), 0);
        check("rst_count_0", int'(bus.oFrame_Cont), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
